// File: rtl/braille_scan_sequencer_if.sv
// Frame handshake bundle between the SPI frame receiver and the braille scan sequencer.
// The master offers a 10-dot target frame and the slave accepts it with frame_ready.
interface braille_scan_sequencer_if;
  logic [9:0] frame_data;
  logic       frame_valid;
  logic       frame_ready;

  modport master (
    output frame_data,
    output frame_valid,
    input  frame_ready
  );

  modport slave (
    input  frame_data,
    input  frame_valid,
    output frame_ready
  );
endinterface

// File: rtl/braille_scan_sequencer.sv
// Walks the 5x2 braille dot matrix and fires timed H-bridge set/clear pulses on dots whose
// target differs from the tracked state; signals completion with a one-cycle trigger_out_n pulse.
module braille_scan_sequencer #(
  parameter int PULSE_CYCLES = 4,
  parameter int DEAD_CYCLES  = 2,
  parameter int CNT_W        = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     i_enable_n,
  input  logic                     i_trigger_in_n,
  braille_scan_sequencer_if.slave  frame_if,
  output logic [4:0]               o_rows,
  output logic [1:0]               o_cols,
  output logic [4:0]               o_rows_enable,
  output logic [1:0]               o_cols_enable,
  output logic [9:0]               o_rows_hbrige,
  output logic [3:0]               o_cols_hbrige,
  output logic                     o_trigger_out_n,
  output logic                     o_busy,
  output logic [9:0]               o_dot_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_SCAN, S_DEAD, S_PULSE, S_DONE
  } state_t;

  state_t           r_state, w_state_next;
  logic [3:0]       r_idx, w_idx_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [9:0]       r_target, w_target_next;
  logic [9:0]       r_dot_state, w_dot_next;

  logic [4:0]       r_rows, w_rows_next;
  logic [1:0]       r_cols, w_cols_next;
  logic [9:0]       r_rows_hb, w_rows_hb_next;
  logic [3:0]       r_cols_hb, w_cols_hb_next;
  logic             r_trig_n, r_busy;

  logic             w_accept, w_last_dot, w_sel, w_set;

  assign frame_if.frame_ready = (r_state == S_IDLE) && !i_enable_n;
  assign w_accept   = frame_if.frame_valid && frame_if.frame_ready;
  assign w_last_dot = (r_idx == 4'd9);

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    w_state_next  = r_state;
    w_idx_next    = r_idx;
    w_cnt_next    = r_cnt;
    w_target_next = r_target;
    w_dot_next    = r_dot_state;

    if (r_state != S_IDLE && i_enable_n) begin
      w_state_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_accept) begin
          w_target_next = frame_if.frame_data;
          w_state_next  = S_ARMED;
        end
        S_ARMED: if (!i_trigger_in_n) begin
          w_idx_next   = 4'd0;
          w_state_next = S_SCAN;
        end
        S_SCAN: if (r_target[r_idx] == r_dot_state[r_idx]) begin
          if (w_last_dot) w_state_next = S_DONE;
          else            w_idx_next   = r_idx + 4'd1;
        end else begin
          w_cnt_next   = CNT_W'(DEAD_CYCLES);
          w_state_next = S_DEAD;
        end
        S_DEAD: if (r_cnt == CNT_W'(1)) begin
          w_cnt_next   = CNT_W'(PULSE_CYCLES);
          w_state_next = S_PULSE;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
        S_PULSE: if (r_cnt == CNT_W'(1)) begin
          w_dot_next[r_idx] = r_target[r_idx];
          if (w_last_dot) begin
            w_state_next = S_DONE;
          end else begin
            w_idx_next   = r_idx + 4'd1;
            w_state_next = S_SCAN;
          end
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
        S_DONE:  w_state_next = S_IDLE;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // Pad outputs are decoded from the next state so the registered pins line up with r_state.
  always_comb begin
    w_sel          = (w_state_next == S_DEAD) || (w_state_next == S_PULSE);
    w_set          = w_target_next[w_idx_next];
    w_rows_next    = w_sel ? (5'(1) << w_idx_next[3:1]) : 5'd0;
    w_cols_next    = w_sel ? (2'(1) << w_idx_next[0])   : 2'd0;
    w_rows_hb_next = 10'd0;
    w_cols_hb_next = 4'd0;
    if (w_state_next == S_PULSE) begin
      w_rows_hb_next = 10'(1) << {w_idx_next[3:1], ~w_set};
      w_cols_hb_next = 4'(1)  << {w_idx_next[0], w_set};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_idx       <= 4'd0;
      r_cnt       <= '0;
      r_target    <= 10'd0;
      r_dot_state <= 10'd0;
      r_rows      <= 5'd0;
      r_cols      <= 2'd0;
      r_rows_hb   <= 10'd0;
      r_cols_hb   <= 4'd0;
      r_trig_n    <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_idx       <= w_idx_next;
      r_cnt       <= w_cnt_next;
      r_target    <= w_target_next;
      r_dot_state <= w_dot_next;
      r_rows      <= w_rows_next;
      r_cols      <= w_cols_next;
      r_rows_hb   <= w_rows_hb_next;
      r_cols_hb   <= w_cols_hb_next;
      r_trig_n    <= (w_state_next != S_DONE);
      r_busy      <= (w_state_next != S_IDLE);
    end
  end

  assign o_rows          = r_rows;
  assign o_cols          = r_cols;
  assign o_rows_enable   = r_rows;
  assign o_cols_enable   = r_cols;
  assign o_rows_hbrige   = r_rows_hb;
  assign o_cols_hbrige   = r_cols_hb;
  assign o_trigger_out_n = r_trig_n;
  assign o_busy          = r_busy;
  assign o_dot_state     = r_dot_state;

endmodule

// File: tb/tb_braille_scan_sequencer.sv
// Directed self-checking bench for braille_scan_sequencer: set, clear, unchanged frame,
// abort, trigger hold, backpressure, simultaneous events and asynchronous reset mid-pulse.
module tb_braille_scan_sequencer;
  logic       clock = 1'b0;
  logic       reset;
  logic       enable_n;
  logic       trigger_in_n;
  logic [4:0] rows, rows_enable;
  logic [1:0] cols, cols_enable;
  logic [9:0] rows_hbrige;
  logic [3:0] cols_hbrige;
  logic       trigger_out_n, busy;
  logic [9:0] dot_state;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int scan_cyc;
  bit to;

  braille_scan_sequencer_if bus ();

  braille_scan_sequencer #(.PULSE_CYCLES(4), .DEAD_CYCLES(2), .CNT_W(16)) dut (
    .clock           (clock),
    .reset           (reset),
    .i_enable_n      (enable_n),
    .i_trigger_in_n  (trigger_in_n),
    .frame_if        (bus),
    .o_rows          (rows),
    .o_cols          (cols),
    .o_rows_enable   (rows_enable),
    .o_cols_enable   (cols_enable),
    .o_rows_hbrige   (rows_hbrige),
    .o_cols_hbrige   (cols_hbrige),
    .o_trigger_out_n (trigger_out_n),
    .o_busy          (busy),
    .o_dot_state     (dot_state)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [9:0] data);
    bus.frame_data  = data;
    bus.frame_valid = 1'b1;
    tick();
    bus.frame_valid = 1'b0;
  endtask

  task automatic wait_done(output bit timed_out);
    timed_out = 1'b1;
    for (int n = 0; n < 200; n++) begin
      if (trigger_out_n === 1'b0) begin
        timed_out = 1'b0;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_bridge(output bit timed_out);
    timed_out = 1'b1;
    for (int n = 0; n < 200; n++) begin
      if (rows_hbrige !== 10'd0) begin
        timed_out = 1'b0;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable_n = 1'b0; trigger_in_n = 1'b1;
    bus.frame_valid = 1'b0; bus.frame_data = 10'd0;
    #12;
    compared++;
    if ({rows, cols, rows_enable, cols_enable, rows_hbrige, cols_hbrige} !== 28'd0) begin
      mismatched++;
      $display("FAIL reset_outputs: got %h want 0", {rows, cols, rows_enable, cols_enable, rows_hbrige, cols_hbrige});
    end
    compared++;
    if ({trigger_out_n, busy, dot_state, bus.frame_ready} !== {1'b1, 1'b0, 10'd0, 1'b1}) begin
      mismatched++;
      $display("FAIL reset_status: trig=%b busy=%b dots=%h ready=%b want 1 0 000 1",
               trigger_out_n, busy, dot_state, bus.frame_ready);
    end
    reset = 1'b0;
    tick();
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_single_set();
    trigger_in_n = 1'b0;
    send_frame(10'h001);
    compared++;
    if ({busy, rows_enable} !== {1'b1, 5'd0}) begin
      mismatched++;
      $display("FAIL set_armed: busy=%b rows_en=%b want 1 00000", busy, rows_enable);
    end
    tick();
    scan_cyc = cyc;
    for (int k = 0; k < 2; k++) begin
      tick();
      compared++;
      if ({rows, cols, rows_enable, cols_enable, rows_hbrige, cols_hbrige} !==
          {5'b00001, 2'b01, 5'b00001, 2'b01, 10'h000, 4'b0000}) begin
        mismatched++;
        $display("FAIL set_dead%0d: rows=%b cols=%b hb=%h/%b want 00001 01 000/0000",
                 k, rows, cols, rows_hbrige, cols_hbrige);
      end
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      compared++;
      if ({rows, cols, rows_hbrige, cols_hbrige} !== {5'b00001, 2'b01, 10'h001, 4'b0010}) begin
        mismatched++;
        $display("FAIL set_pulse%0d: rows=%b cols=%b hb=%h/%b want 00001 01 001/0010",
                 k, rows, cols, rows_hbrige, cols_hbrige);
      end
    end
    wait_done(to);
    compared++;
    if (to || (cyc - scan_cyc) != 16) begin
      mismatched++;
      $display("FAIL set_latency: timeout=%0d cycles=%0d want 16", to, cyc - scan_cyc);
    end
    compared++;
    if (dot_state !== 10'h001) begin
      mismatched++;
      $display("FAIL set_dot_state: got %h want 001", dot_state);
    end
    tick();
    compared++;
    if ({trigger_out_n, busy} !== 2'b10) begin
      mismatched++;
      $display("FAIL set_done_pulse: trig=%b busy=%b want 1 0", trigger_out_n, busy);
    end
  endtask

  task automatic test_unchanged();
    logic [20:0] act;
    int n;
    act = '0;
    n = 0;
    send_frame(10'h001);
    tick();
    scan_cyc = cyc;
    while (trigger_out_n !== 1'b0 && n < 200) begin
      act |= {rows_enable, cols_enable, rows_hbrige, cols_hbrige};
      tick();
      n++;
    end
    compared++;
    if (act !== 21'd0) begin
      mismatched++;
      $display("FAIL unchanged_activity: got %h want 0", act);
    end
    compared++;
    if (trigger_out_n !== 1'b0 || (cyc - scan_cyc) != 10) begin
      mismatched++;
      $display("FAIL unchanged_latency: trig=%b cycles=%0d want 0 10", trigger_out_n, cyc - scan_cyc);
    end
    tick();
  endtask

  task automatic test_clear_dot9();
    send_frame(10'h200);
    tick();
    scan_cyc = cyc;
    wait_bridge(to);
    compared++;
    if (to || {rows_hbrige, cols_hbrige} !== {10'h002, 4'b0001} || (cyc - scan_cyc) != 3) begin
      mismatched++;
      $display("FAIL clear0_pulse: hb=%h/%b at %0d want 002/0001 at 3",
               rows_hbrige, cols_hbrige, cyc - scan_cyc);
    end
    wait_done(to);
    compared++;
    if (to || (cyc - scan_cyc) != 22 || dot_state !== 10'h200) begin
      mismatched++;
      $display("FAIL swap_done: cycles=%0d dots=%h want 22 200", cyc - scan_cyc, dot_state);
    end
    tick();
    send_frame(10'h000);
    tick();
    scan_cyc = cyc;
    wait_bridge(to);
    compared++;
    if (to || {rows, cols, rows_enable, cols_enable, rows_hbrige, cols_hbrige} !==
        {5'b10000, 2'b10, 5'b10000, 2'b10, 10'h200, 4'b0100} || (cyc - scan_cyc) != 12) begin
      mismatched++;
      $display("FAIL clear9_pulse: rows=%b cols=%b hb=%h/%b at %0d want 10000 10 200/0100 at 12",
               rows, cols, rows_hbrige, cols_hbrige, cyc - scan_cyc);
    end
    wait_done(to);
    compared++;
    if (to || (cyc - scan_cyc) != 16 || dot_state !== 10'h000) begin
      mismatched++;
      $display("FAIL clear9_done: cycles=%0d dots=%h want 16 000", cyc - scan_cyc, dot_state);
    end
    tick();
  endtask

  task automatic test_abort();
    bit trig_seen;
    trig_seen = 1'b0;
    send_frame(10'h010);
    tick();
    wait_bridge(to);
    compared++;
    if (to || {rows_hbrige, cols_hbrige} !== {10'h010, 4'b0010}) begin
      mismatched++;
      $display("FAIL abort_pulse: hb=%h/%b want 010/0010", rows_hbrige, cols_hbrige);
    end
    tick();
    enable_n = 1'b1;
    tick();
    compared++;
    if ({rows, cols, rows_enable, cols_enable, rows_hbrige, cols_hbrige} !== 28'd0) begin
      mismatched++;
      $display("FAIL abort_outputs: got %h want 0", {rows, cols, rows_enable, cols_enable, rows_hbrige, cols_hbrige});
    end
    compared++;
    if ({busy, trigger_out_n, dot_state, bus.frame_ready} !== {1'b0, 1'b1, 10'h000, 1'b0}) begin
      mismatched++;
      $display("FAIL abort_status: busy=%b trig=%b dots=%h ready=%b want 0 1 000 0",
               busy, trigger_out_n, dot_state, bus.frame_ready);
    end
    for (int k = 0; k < 20; k++) begin
      tick();
      if (trigger_out_n !== 1'b1) trig_seen = 1'b1;
    end
    compared++;
    if (trig_seen) begin
      mismatched++;
      $display("FAIL abort_no_trigger: pulse seen=%b want 0", trig_seen);
    end
    enable_n = 1'b0;
    #1;
    compared++;
    if (bus.frame_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL abort_ready: got %b want 1", bus.frame_ready);
    end
    tick();
  endtask

  task automatic test_hold_backpressure();
    bit bad;
    bad = 1'b0;
    trigger_in_n = 1'b1;
    send_frame(10'h003);
    for (int k = 0; k < 5; k++) begin
      tick();
      if ({busy, trigger_out_n, rows_enable, cols_enable, rows_hbrige, cols_hbrige} !== {1'b1, 1'b1, 21'd0})
        bad = 1'b1;
    end
    compared++;
    if (bad) begin
      mismatched++;
      $display("FAIL hold_armed: outputs active=%b want 0", bad);
    end
    trigger_in_n = 1'b0;
    tick();
    scan_cyc = cyc;
    compared++;
    if (rows_enable !== 5'd0) begin
      mismatched++;
      $display("FAIL hold_scan: rows_en=%b want 00000", rows_enable);
    end
    tick();
    compared++;
    if (rows_enable !== 5'b00001) begin
      mismatched++;
      $display("FAIL hold_dead: rows_en=%b want 00001", rows_enable);
    end
    bus.frame_data  = 10'h3FF;
    bus.frame_valid = 1'b1;
    #1;
    compared++;
    if (bus.frame_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL backpressure_ready: got %b want 0", bus.frame_ready);
    end
    wait_done(to);
    bus.frame_valid = 1'b0;
    compared++;
    if (to || (cyc - scan_cyc) != 22 || dot_state !== 10'h003) begin
      mismatched++;
      $display("FAIL backpressure_done: cycles=%0d dots=%h want 22 003", cyc - scan_cyc, dot_state);
    end
    tick();
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL backpressure_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_simultaneous();
    bus.frame_data  = 10'h3FF;
    bus.frame_valid = 1'b1;
    enable_n        = 1'b1;
    #1;
    compared++;
    if (bus.frame_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL sim_offer_ready: got %b want 0", bus.frame_ready);
    end
    tick();
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL sim_offer_busy: got %b want 0", busy);
    end
    bus.frame_valid = 1'b0;
    enable_n        = 1'b0;
    trigger_in_n    = 1'b1;
    send_frame(10'h3FF);
    trigger_in_n = 1'b0;
    enable_n     = 1'b1;
    tick();
    compared++;
    if ({busy, trigger_out_n, rows_enable} !== {1'b0, 1'b1, 5'd0}) begin
      mismatched++;
      $display("FAIL sim_armed_abort: busy=%b trig=%b rows_en=%b want 0 1 00000",
               busy, trigger_out_n, rows_enable);
    end
    enable_n = 1'b0;
    tick();
    tick();
    compared++;
    if ({busy, dot_state} !== {1'b0, 10'h003}) begin
      mismatched++;
      $display("FAIL sim_discard: busy=%b dots=%h want 0 003", busy, dot_state);
    end
  endtask

  task automatic test_reset_mid_pulse();
    send_frame(10'h000);
    tick();
    wait_bridge(to);
    compared++;
    if (to || {rows_hbrige, cols_hbrige} !== {10'h002, 4'b0001}) begin
      mismatched++;
      $display("FAIL rst_pulse_setup: hb=%h/%b want 002/0001", rows_hbrige, cols_hbrige);
    end
    #2;
    reset = 1'b1;
    #1;
    compared++;
    if ({rows_hbrige, cols_hbrige, rows_enable, dot_state, busy, trigger_out_n} !==
        {10'h000, 4'b0000, 5'd0, 10'h000, 1'b0, 1'b1}) begin
      mismatched++;
      $display("FAIL rst_async: hb=%h/%b rows_en=%b dots=%h busy=%b trig=%b want 000/0000 00000 000 0 1",
               rows_hbrige, cols_hbrige, rows_enable, dot_state, busy, trigger_out_n);
    end
    #1;
    reset = 1'b0;
    tick();
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_after: busy=%b want 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_set();
    test_unchanged();
    test_clear_dot9();
    test_abort();
    test_hold_backpressure();
    test_simultaneous();
    test_reset_mid_pulse();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
